booth_seq_mult: RTL and testbench

- Sequential radix-2 Booth multiplier controller with a parameterised operand width.
- Owns the accumulator, multiplier and Q(-1) registers plus a step counter, and applies one Booth add/sub-and-shift step per clock.
- Accepts signed operand pairs over a valid/ready input handshake and returns the 2*WIDTH signed product over a valid/ready output handshake.
- Sits between operand producers and product consumers in the arithmetic datapath. Replaces fully unrolled step chains where area matters more than latency.

---
 rtl/booth_pkg.sv | 44 ++++
 rtl/booth_radix2_step.sv | 49 ++++
 rtl/booth_seq_mult.sv | 155 +++++++++++++++
 tb/tb_booth_seq_mult.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
// Module  : booth_pkg
// Purpose : Shared types and helpers for the radix-2 Booth multiplier family.
//           - Controller state encoding (IDLE / RUN / DONE)
//           - Booth pair encodings for {Q[0], q_m1}
//           - Step-counter width helper
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package booth_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Booth operation selected by the pair {Q[0], q_m1}.
    typedef enum logic [1:0] {
        BOOTH_NOP = 2'b00,
        BOOTH_ADD = 2'b01,
        BOOTH_SUB = 2'b10
    } booth_op_e;

    // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
    function automatic int booth_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    // 01 -> end of a run of ones: add M.
    // 10 -> start of a run of ones: subtract M.
    // 00 / 11 -> inside a run: no add.
    function automatic booth_op_e booth_decode(input logic q0, input logic q_m1);
        case ({q0, q_m1})
            2'b01:   return BOOTH_ADD;
            2'b10:   return BOOTH_SUB;
            default: return BOOTH_NOP;
        endcase
    endfunction

endpackage : booth_pkg
`default_nettype wire

// File: rtl/booth_radix2_step.sv
`default_nettype none
// ============================================================================
// Module  : booth_radix2_step
// Purpose : One combinational radix-2 Booth iteration: conditional add/sub of
//           the multiplicand into the accumulator, followed by an arithmetic
//           right shift of {A, Q, q_m1}.
// Ports   : a         in  WIDTH+1  accumulator (one guard bit)
//           q         in  WIDTH    multiplier / low product bits
//           q_m1      in  1        Q(-1) history bit
//           m         in  WIDTH    signed multiplicand
//           a_next    out WIDTH+1  accumulator after add/sub and shift
//           q_next    out WIDTH    Q after shift
//           q_m1_next out 1        new Q(-1) (old Q[0])
// Revision: 1.0  initial release
// ============================================================================
module booth_radix2_step
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic             q_m1,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   a_next,
    output logic [WIDTH-1:0] q_next,
    output logic             q_m1_next
);

    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] sum;

    always_comb begin
        // Sign-extend M into the guard bit so A-M cannot overflow even for
        // the most negative multiplicand.
        m_ext = {m[WIDTH-1], m};
        case (booth_decode(q[0], q_m1))
            BOOTH_ADD: sum = a + m_ext;
            BOOTH_SUB: sum = a - m_ext;
            default:   sum = a;
        endcase
        // Arithmetic right shift of {sum, q, q_m1}: sign of A replicated.
        a_next    = {sum[WIDTH], sum[WIDTH:1]};
        q_next    = {sum[0], q[WIDTH-1:1]};
        q_m1_next = q[0];
    end

endmodule : booth_radix2_step
`default_nettype wire

// File: rtl/booth_seq_mult.sv
`default_nettype none
// ============================================================================
// Module  : booth_seq_mult
// Purpose : Sequential radix-2 Booth multiplier. Accepts a signed operand
//           pair over a valid/ready handshake, performs one Booth step per
//           clock for WIDTH clocks, then presents the 2*WIDTH signed product
//           over a valid/ready handshake.
// Ports   : clk          in  1        rising-edge clock
//           rst_n        in  1        asynchronous active-low reset
//           in_valid     in  1        operand pair valid
//           in_ready     out 1        ready for operands (IDLE only)
//           multiplier   in  WIDTH    signed multiplier (Q)
//           multiplicand in  WIDTH    signed multiplicand (M)
//           out_valid    out 1        product valid (DONE only)
//           out_ready    in  1        consumer accepts product
//           product      out 2*WIDTH  registered signed product
//           busy         out 1        operation in flight (RUN or DONE)
// Revision: 1.0  initial release
// ============================================================================
module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = booth_cnt_w(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     multiplicand,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    generate
        if (WIDTH < 2) begin : g_width_check
            $error("booth_seq_mult: WIDTH must be >= 2");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_e               state_q,   state_d;
    logic [WIDTH:0]       a_q,       a_d;
    logic [WIDTH-1:0]     q_q,       q_d;
    logic                 q_m1_q,    q_m1_d;
    logic [WIDTH-1:0]     m_q,       m_d;
    logic [CNT_W-1:0]     count_q,   count_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    // Outputs of the combinational Booth step
    logic [WIDTH:0]       step_a;
    logic [WIDTH-1:0]     step_q;
    logic                 step_q_m1;

    booth_radix2_step #(
        .WIDTH     (WIDTH)
    ) u_step (
        .a         (a_q),
        .q         (q_q),
        .q_m1      (q_m1_q),
        .m         (m_q),
        .a_next    (step_a),
        .q_next    (step_q),
        .q_m1_next (step_q_m1)
    );

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        q_m1_d    = q_m1_q;
        m_d       = m_q;
        count_d   = count_q;
        product_d = product_q;

        case (state_q)
            IDLE: begin
                // in_ready is high throughout IDLE, so in_valid alone
                // completes the handshake here.
                if (in_valid) begin
                    a_d     = '0;
                    q_d     = multiplier;
                    q_m1_d  = 1'b0;
                    m_d     = multiplicand;
                    count_d = CNT_W'(WIDTH);
                    state_d = RUN;
                end
            end

            RUN: begin
                a_d     = step_a;
                q_d     = step_q;
                q_m1_d  = step_q_m1;
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    // Final step: the guard bit of A is dropped; the low
                    // 2*WIDTH bits of {A,Q} are exact for every operand pair.
                    product_d = {step_a[WIDTH-1:0], step_q};
                    state_d   = DONE;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            q_q       <= '0;
            q_m1_q    <= 1'b0;
            m_q       <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            q_m1_q    <= q_m1_d;
            m_q       <= m_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state only
    // ------------------------------------------------------------------
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign product   = product_q;

endmodule : booth_seq_mult
`default_nettype wire

// File: tb/tb_booth_seq_mult.sv
`default_nettype none
// ============================================================================
// Module  : tb_booth_seq_mult
// Purpose : Self-checking bench for booth_seq_mult. Three instances
//           (WIDTH = 8, 2, 16). Stimulus pushes reference products into
//           queues; monitors pop and compare on each output handshake and
//           also check latency and back-to-back spacing.
// Revision: 1.0  initial release
// ============================================================================
module tb_booth_seq_mult;

    logic clk;
    int   cyc;
    int   n_checks;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- WIDTH = 8 instance ----------------
    logic        rst_n;
    logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [7:0]  mr8, md8;
    logic [15:0] product8;

    booth_seq_mult #(.WIDTH(8)) u_dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid8),
        .in_ready     (in_ready8),
        .multiplier   (mr8),
        .multiplicand (md8),
        .out_valid    (out_valid8),
        .out_ready    (out_ready8),
        .product      (product8),
        .busy         (busy8)
    );

    // ---------------- WIDTH = 2 and 16 instances ----------------
    logic        rst_b_n;
    logic        in_valid2, in_ready2, out_valid2, out_ready2, busy2;
    logic [1:0]  mr2, md2;
    logic [3:0]  product2;
    logic        in_valid16, in_ready16, out_valid16, out_ready16, busy16;
    logic [15:0] mr16, md16;
    logic [31:0] product16;

    booth_seq_mult #(.WIDTH(2)) u_dut2 (
        .clk          (clk),
        .rst_n        (rst_b_n),
        .in_valid     (in_valid2),
        .in_ready     (in_ready2),
        .multiplier   (mr2),
        .multiplicand (md2),
        .out_valid    (out_valid2),
        .out_ready    (out_ready2),
        .product      (product2),
        .busy         (busy2)
    );

    booth_seq_mult #(.WIDTH(16)) u_dut16 (
        .clk          (clk),
        .rst_n        (rst_b_n),
        .in_valid     (in_valid16),
        .in_ready     (in_ready16),
        .multiplier   (mr16),
        .multiplicand (md16),
        .out_valid    (out_valid16),
        .out_ready    (out_ready16),
        .product      (product16),
        .busy         (busy16)
    );

    // ---------------- scoreboard state ----------------
    longint exp8[$];
    longint exp2[$];
    longint exp16[$];
    int     lat8[$];
    bit     b2b8;
    int     last8;
    bit     done2, done16;

    // Reference: signed product of two w-bit two's complement values,
    // truncated to 2*w bits.
    function automatic longint sx(input longint v, input int w);
        longint half;
        half = longint'(1) << (w - 1);
        return (v >= half) ? v - (longint'(1) << w) : v;
    endfunction

    function automatic longint model(input longint a, input longint b, input int w);
        longint p;
        p = sx(a, w) * sx(b, w);
        return p & ((longint'(1) << (2 * w)) - 1);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Drive an operand pair and wait for the accepting edge. Returns #1
    // after that edge. hold keeps in_valid high for back-to-back streams.
    task automatic send8(input logic [7:0] a, input logic [7:0] b, input bit hold);
        bit acc;
        int t;
        mr8       = a;
        md8       = b;
        in_valid8 = 1'b1;
        t = 0;
        do begin
            acc = in_ready8;
            @(posedge clk);
            #1;
            t++;
        end while (!acc && t < 200);
        if (!acc) fail("accept8_timeout", "got no accept, expected in_ready within 200 cycles");
        else      exp8.push_back(model(longint'(a), longint'(b), 8));
        if (!hold) in_valid8 = 1'b0;
    endtask

    task automatic wait_out8();
        int t;
        t = 0;
        while (!out_valid8 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!out_valid8) fail("out_valid8_timeout", "got out_valid=0, expected 1 within 50 cycles");
    endtask

    task automatic wait_idle8();
        int t;
        t = 0;
        while (!in_ready8 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_ready8) fail("in_ready8_timeout", "got in_ready=0, expected 1 within 50 cycles");
    endtask

    // ---------------- monitor: WIDTH = 8 ----------------
    initial begin : mon8
        bit ov_prev;
        int e;
        ov_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ov_prev = 1'b0;
                continue;
            end
            if (in_valid8 && in_ready8) lat8.push_back(cyc + 1);
            if (out_valid8 && !ov_prev) begin
                if (lat8.size() == 0) fail("latency8", "got out_valid with no accepted operands");
                else begin
                    e = lat8.pop_front();
                    chk("latency8", longint'(cyc - e), 8);
                end
            end
            if (out_valid8 && out_ready8) begin
                if (exp8.size() == 0) fail("product8", "got a product handshake, expected none");
                else chk("product8", longint'(product8), exp8.pop_front());
                if (b2b8 && last8 >= 0) chk("spacing8", longint'(cyc - last8), 10);
                last8 = cyc;
            end
            ov_prev = out_valid8;
        end
    end

    // ---------------- monitor: WIDTH = 2 / 16 ----------------
    initial begin : mon_b
        int last2, last16;
        last2  = -1;
        last16 = -1;
        forever begin
            @(negedge clk);
            if (rst_b_n) begin
                if (out_valid2 && out_ready2) begin
                    if (exp2.size() == 0) fail("product2", "got a product handshake, expected none");
                    else chk("product2", longint'(product2), exp2.pop_front());
                    if (last2 >= 0) chk("spacing2", longint'(cyc - last2), 4);
                    last2 = cyc;
                end
                if (out_valid16 && out_ready16) begin
                    if (exp16.size() == 0) fail("product16", "got a product handshake, expected none");
                    else chk("product16", longint'(product16), exp16.pop_front());
                    if (last16 >= 0) chk("spacing16", longint'(cyc - last16), 18);
                    last16 = cyc;
                end
            end
        end
    end

    // ---------------- reset for WIDTH = 2 / 16 ----------------
    initial begin : rst_b
        rst_b_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_b_n = 1'b1;
    end

    // ---------------- stream: WIDTH = 2 ----------------
    initial begin : stream2
        logic [1:0] a, b;
        bit acc;
        int t;
        in_valid2  = 1'b0;
        mr2        = '0;
        md2        = '0;
        out_ready2 = 1'b1;
        done2      = 1'b0;
        wait (rst_b_n === 1'b1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 100; i++) begin
            a = 2'($urandom);
            b = 2'($urandom);
            mr2 = a;
            md2 = b;
            in_valid2 = 1'b1;
            t = 0;
            do begin
                acc = in_ready2;
                @(posedge clk);
                #1;
                t++;
            end while (!acc && t < 50);
            if (!acc) fail("accept2_timeout", "got no accept, expected in_ready within 50 cycles");
            else      exp2.push_back(model(longint'(a), longint'(b), 2));
        end
        in_valid2 = 1'b0;
        done2 = 1'b1;
    end

    // ---------------- stream: WIDTH = 16 ----------------
    initial begin : stream16
        logic [15:0] a, b;
        bit acc;
        int t;
        in_valid16  = 1'b0;
        mr16        = '0;
        md16        = '0;
        out_ready16 = 1'b1;
        done16      = 1'b0;
        wait (rst_b_n === 1'b1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 100; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if (i == 0) begin
                a = 16'h8000;
                b = 16'h8000;
            end
            mr16 = a;
            md16 = b;
            in_valid16 = 1'b1;
            t = 0;
            do begin
                acc = in_ready16;
                @(posedge clk);
                #1;
                t++;
            end while (!acc && t < 60);
            if (!acc) fail("accept16_timeout", "got no accept, expected in_ready within 60 cycles");
            else      exp16.push_back(model(longint'(a), longint'(b), 16));
        end
        in_valid16 = 1'b0;
        done16 = 1'b1;
    end

    // ---------------- watchdog ----------------
    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running at 500000 ns, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main directed sequence (WIDTH = 8) ----------------
    initial begin : main
        longint e_hold;
        logic [7:0] ra, rb;
        int t;
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        in_valid8  = 1'b0;
        out_ready8 = 1'b0;
        mr8        = '0;
        md8        = '0;
        b2b8       = 1'b0;
        last8      = -1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  longint'(in_ready8),  1);
        chk("rst_out_valid", longint'(out_valid8), 0);
        chk("rst_busy",      longint'(busy8),      0);
        chk("rst_product",   longint'(product8),   0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 3 x 5, then in_ready one cycle after the output handshake
        out_ready8 = 1'b1;
        send8(8'd3, 8'd5, 1'b0);
        chk("busy_in_run", longint'(busy8), 1);
        wait_out8();
        chk("busy_in_done", longint'(busy8), 1);
        @(posedge clk);
        #1;
        chk("in_ready_after_hs", longint'(in_ready8), 1);

        // signed and corner operands
        send8(8'hF9, 8'h06, 1'b0); wait_idle8();
        send8(8'h80, 8'h80, 1'b0); wait_idle8();
        send8(8'h80, 8'h7F, 1'b0); wait_idle8();
        send8(8'hFF, 8'hFF, 1'b0); wait_idle8();
        send8(8'h00, 8'h80, 1'b0); wait_idle8();

        // output back-pressure with in_valid pulsed while DONE
        out_ready8 = 1'b0;
        send8(8'h12, 8'h34, 1'b0);
        e_hold = model(64'h12, 64'h34, 8);
        wait_out8();
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                mr8 = 8'h55;
                md8 = 8'h66;
                in_valid8 = 1'b1;
            end
            if (i == 3) in_valid8 = 1'b0;
            chk("hold_out_valid", longint'(out_valid8), 1);
            chk("hold_product",   longint'(product8),   e_hold);
            chk("hold_in_ready",  longint'(in_ready8),  0);
            @(posedge clk);
            #1;
        end
        out_ready8 = 1'b1;
        @(posedge clk);
        #1;
        chk("release_in_ready",  longint'(in_ready8),  1);
        chk("release_out_valid", longint'(out_valid8), 0);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("no_spurious_start", longint'(busy8), 0);
        end

        // asynchronous reset during RUN step 4
        send8(8'h11, 8'h22, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp8.delete();
        lat8.delete();
        #1;
        chk("arst_out_valid", longint'(out_valid8), 0);
        chk("arst_product",   longint'(product8),   0);
        chk("arst_busy",      longint'(busy8),      0);
        chk("arst_in_ready",  longint'(in_ready8),  1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send8(8'd2, 8'hFD, 1'b0);
        wait_idle8();

        // back-to-back random stream
        b2b8  = 1'b1;
        last8 = -1;
        for (int i = 0; i < 100; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            send8(ra, rb, 1'b1);
        end
        in_valid8 = 1'b0;
        wait_idle8();
        b2b8 = 1'b0;

        // wait for the WIDTH = 2 / 16 streams and drain
        t = 0;
        while (!(done2 && done16) && t < 4000) begin
            @(posedge clk);
            t++;
        end
        if (!(done2 && done16)) fail("streams_timeout", "got unfinished W2/W16 streams, expected done");
        repeat (40) @(posedge clk);
        #1;
        chk("exp8_drained",  longint'(exp8.size()),  0);
        chk("exp2_drained",  longint'(exp2.size()),  0);
        chk("exp16_drained", longint'(exp16.size()), 0);
        chk("busy2_idle",    longint'(busy2),        0);
        chk("busy16_idle",   longint'(busy16),       0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_booth_seq_mult
`default_nettype wire
